// File: rtl/mesm6_ifetch_pkg.sv
// Shared definitions for the MESM-6 instruction prefetch queue.
package mesm6_ifetch_pkg;

    localparam int unsigned IFQ_DEPTH_DEFAULT = 4;
    localparam int unsigned IFQ_AW_DEFAULT    = 15;
    localparam int unsigned IFQ_DW_DEFAULT    = 48;

    // op_pc[0] selects which half of the head word is the current opcode.
    localparam logic HALF_LEFT  = 1'b0;
    localparam logic HALF_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IFQ_IDLE,
        IFQ_RUN,
        IFQ_DRAIN
    } ifq_state_t;

endpackage

// File: rtl/mesm6_ifetch_buf.sv
// DEPTH x DW circular word buffer with push, pop, clear, occupancy and head word.
module mesm6_ifetch_buf
    import mesm6_ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH_DEFAULT,
    parameter int unsigned DW    = IFQ_DW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DW-1:0]              head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/mesm6_ifetch_queue.sv
// MESM-6 instruction prefetch queue: FSM, fetch/PC counters and opcode select.
// Optional saturating performance counters under `MESM6_IFETCH_PERF_EN.
module mesm6_ifetch_queue
    import mesm6_ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH_DEFAULT,
    parameter int unsigned AW    = IFQ_AW_DEFAULT,
    parameter int unsigned DW    = IFQ_DW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect,
    input  logic [AW:0]     redirect_pc,
    output logic            ibus_fetch,
    output logic [AW-1:0]   ibus_addr,
    input  logic [DW-1:0]   ibus_input,
    input  logic            ibus_done,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [DW/2-1:0] opcode,
    output logic [AW:0]     op_pc
`ifdef MESM6_IFETCH_PERF_EN
   ,output logic [31:0]     perf_fetches,
    output logic [15:0]     perf_discards
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    ifq_state_t    state_q, state_d;
    logic          fetch_q, fetch_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] target_q, target_d;
    logic [AW:0]   pc_q, pc_d;

    logic          buf_clear, buf_push, buf_pop;
    logic [CW-1:0] buf_count, count_after;
    logic [DW-1:0] buf_head;
    logic          done_ev, consume;

    assign done_ev = fetch_q & ibus_done;
    assign consume = op_valid & op_ready;

    mesm6_ifetch_buf #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (buf_clear),
        .push      (buf_push),
        .push_data (ibus_input),
        .pop       (buf_pop),
        .count     (buf_count),
        .head      (buf_head)
    );

    always_comb begin
        state_d     = state_q;
        fetch_d     = fetch_q;
        addr_d      = addr_q;
        target_d    = target_q;
        pc_d        = pc_q;
        buf_clear   = 1'b0;
        buf_push    = 1'b0;
        buf_pop     = 1'b0;
        count_after = buf_count;
        unique case (state_q)
            IFQ_IDLE: begin
                if (redirect) begin
                    buf_clear = 1'b1;
                    pc_d      = redirect_pc;
                    addr_d    = redirect_pc[AW:1];
                    fetch_d   = 1'b1;
                    state_d   = IFQ_RUN;
                end
            end
            IFQ_RUN: begin
                if (redirect) begin
                    buf_clear = 1'b1;
                    pc_d      = redirect_pc;
                    if (fetch_q && !ibus_done) begin
                        // Bus request cannot be withdrawn: hold it and drop its data later.
                        target_d = redirect_pc[AW:1];
                        state_d  = IFQ_DRAIN;
                    end else begin
                        addr_d  = redirect_pc[AW:1];
                        fetch_d = 1'b1;
                    end
                end else begin
                    buf_push    = done_ev;
                    buf_pop     = consume & (pc_q[0] == HALF_RIGHT);
                    count_after = buf_count + CW'(buf_push) - CW'(buf_pop);
                    if (consume) pc_d = pc_q + (AW+1)'(1);
                    if (done_ev) addr_d = addr_q + AW'(1);
                    if (!fetch_q || done_ev) fetch_d = (count_after < FULL);
                end
            end
            IFQ_DRAIN: begin
                if (redirect) begin
                    pc_d     = redirect_pc;
                    target_d = redirect_pc[AW:1];
                end
                if (done_ev) begin
                    addr_d  = redirect ? redirect_pc[AW:1] : target_q;
                    fetch_d = 1'b1;
                    state_d = IFQ_RUN;
                end
            end
            default: state_d = IFQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IFQ_IDLE;
            fetch_q  <= 1'b0;
            addr_q   <= '0;
            target_q <= '0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            fetch_q  <= fetch_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            pc_q     <= pc_d;
        end
    end

    assign ibus_fetch = fetch_q;
    assign ibus_addr  = addr_q;
    assign op_pc      = pc_q;
    assign op_valid   = (buf_count != '0) && (state_q != IFQ_DRAIN);

    always_comb begin
        opcode = '0;
        if (op_valid) begin
            opcode = (pc_q[0] == HALF_RIGHT) ? buf_head[DW/2-1:0] : buf_head[DW-1:DW/2];
        end
    end

`ifdef MESM6_IFETCH_PERF_EN
    logic [31:0] perf_fetches_q;
    logic [15:0] perf_discards_q;
    logic [CW:0] disc_inc;
    logic [32:0] fetch_sum;
    logic [16:0] disc_sum;

    // Flushed queue words plus any fetched word whose data is thrown away.
    always_comb begin
        disc_inc = '0;
        if (state_q == IFQ_RUN && redirect) begin
            disc_inc = (CW+1)'(buf_count) + (CW+1)'(done_ev);
        end else if (state_q == IFQ_DRAIN && done_ev) begin
            disc_inc = (CW+1)'(1);
        end
    end

    assign fetch_sum = {1'b0, perf_fetches_q} + 33'(buf_push);
    assign disc_sum  = {1'b0, perf_discards_q} + 17'(disc_inc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetches_q  <= '0;
            perf_discards_q <= '0;
        end else begin
            perf_fetches_q  <= fetch_sum[32] ? '1 : fetch_sum[31:0];
            perf_discards_q <= disc_sum[16] ? '1 : disc_sum[15:0];
        end
    end

    assign perf_fetches  = perf_fetches_q;
    assign perf_discards = perf_discards_q;
`endif

endmodule
